panda_risc_v_icb_dtcm: RTL and testbench

- ICB slave (responder) fronting a single-port, word-organised data tightly-coupled memory (DTCM).
- Sits on the far end of the execution unit's data ICB master: accepts load/store commands, performs byte-masked writes and reads, and returns in-order responses.
- Supports up to 2 outstanding commands, never responds in the same cycle as the command (non-zero latency), and flags out-of-range accesses with rsp_err.

---
 rtl/panda_risc_v_icb_dtcm.sv | 138 +++++++++++++
 tb/tb_panda_risc_v_icb_dtcm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_risc_v_icb_dtcm.sv
// ICB responder in front of a single-port, word-organised data TCM.
// Allows up to two commands in flight and returns responses in order through a 2-entry fall-through FIFO.
module panda_risc_v_icb_dtcm #(
  parameter logic [31:0] base_addr        = 32'h1000_0000,
  parameter int          mem_depth        = 4096,
  parameter int          simulation_delay = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_icb_cmd_addr,
  input  logic        s_icb_cmd_read,
  input  logic [31:0] s_icb_cmd_wdata,
  input  logic [3:0]  s_icb_cmd_wmask,
  input  logic        s_icb_cmd_valid,
  output logic        s_icb_cmd_ready,
  output logic [31:0] s_icb_rsp_rdata,
  output logic        s_icb_rsp_err,
  output logic        s_icb_rsp_valid,
  input  logic        s_icb_rsp_ready
);

  localparam int          aw   = $clog2(4 * mem_depth);
  localparam logic [31:0] span = 32'(4 * mem_depth);

  logic [1:0]    cnt;
  logic          accept;
  logic          rsp_done;
  logic [31:0]   off;
  logic          hit;
  logic [aw-3:0] idx;

  assign s_icb_cmd_ready = (cnt != 2'd2);
  assign accept          = s_icb_cmd_valid & s_icb_cmd_ready;
  assign rsp_done        = s_icb_rsp_valid & s_icb_rsp_ready;

  // Unsigned wrap makes addresses below the base land far above span and miss.
  assign off = s_icb_cmd_addr - base_addr;
  assign hit = off < span;
  assign idx = off[aw-1:2];

  logic unused_bits;
  assign unused_bits = ^{off[1:0], simulation_delay[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
    end else begin
      case ({accept, rsp_done})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  logic [31:0] mem [mem_depth];
  logic [31:0] mem_q;

  always_ff @(posedge clk) begin
    if (accept & hit) begin
      if (s_icb_cmd_read) begin
        mem_q <= mem[idx];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (s_icb_cmd_wmask[b]) mem[idx][8*b +: 8] <= s_icb_cmd_wdata[8*b +: 8];
        end
      end
    end
  end

  logic        st_valid;
  logic        st_read;
  logic        st_err;
  logic [31:0] st_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid <= 1'b0;
      st_read  <= 1'b0;
      st_err   <= 1'b0;
    end else begin
      st_valid <= accept;
      if (accept) begin
        st_read <= s_icb_cmd_read;
        st_err  <= ~hit;
      end
    end
  end

  // mem_q is only meaningful for a hit read; writes and misses report zero.
  assign st_rdata = (st_read & ~st_err) ? mem_q : 32'd0;

  logic [32:0] fifo_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  fifo_cnt;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  assign fifo_empty = (fifo_cnt == 2'd0);
  assign push       = st_valid & ~(fifo_empty & s_icb_rsp_ready);
  assign pop        = ~fifo_empty & s_icb_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {st_err, st_rdata};
  end

  assign s_icb_rsp_valid = ~fifo_empty | st_valid;

  always_comb begin
    s_icb_rsp_err   = 1'b0;
    s_icb_rsp_rdata = 32'd0;
    if (!fifo_empty) begin
      {s_icb_rsp_err, s_icb_rsp_rdata} = fifo_mem[rd_ptr];
    end else if (st_valid) begin
      s_icb_rsp_err   = st_err;
      s_icb_rsp_rdata = st_rdata;
    end
  end

endmodule

// File: tb/tb_panda_risc_v_icb_dtcm.sv
// Bench for panda_risc_v_icb_dtcm: directed vector table, hand-written timing sequences,
// and randomized traffic checked by an in-order scoreboard with a word-array memory model.
module tb_panda_risc_v_icb_dtcm;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;

  always #5 clk = ~clk;

  panda_risc_v_icb_dtcm #(.base_addr(BASE), .mem_depth(DEPTH), .simulation_delay(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_icb_cmd_addr  (cmd_addr),
    .s_icb_cmd_read  (cmd_read),
    .s_icb_cmd_wdata (cmd_wdata),
    .s_icb_cmd_wmask (cmd_wmask),
    .s_icb_cmd_valid (cmd_valid),
    .s_icb_cmd_ready (cmd_ready),
    .s_icb_rsp_rdata (rsp_rdata),
    .s_icb_rsp_err   (rsp_err),
    .s_icb_rsp_valid (rsp_valid),
    .s_icb_rsp_ready (rsp_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Reference model: a sparse word array plus the queue of responses still owed.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          known;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [int];

  function automatic exp_t model_cmd(input bit rd, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] wm);
    exp_t          e;
    longint        ua;
    int            w;
    logic [31:0]   word;
    ua = longint'(a);
    e.rdata = 32'd0;
    e.err   = 1'b0;
    e.known = 1'b1;
    if (ua < longint'(BASE) || ua >= longint'(BASE) + 4 * DEPTH) begin
      e.err = 1'b1;
    end else begin
      w = int'((ua - longint'(BASE)) / 4);
      if (rd) begin
        e.known = mdl.exists(w);
        if (e.known) e.rdata = mdl[w];
      end else if (mdl.exists(w) || wm == 4'hF) begin
        word = mdl.exists(w) ? mdl[w] : 32'd0;
        for (int b = 0; b < 4; b++) if (wm[b]) word[8*b +: 8] = wd[8*b +: 8];
        mdl[w] = word;
      end
    end
    return e;
  endfunction

  bit          prev_stall = 1'b0;
  logic [31:0] prev_rdata;
  logic        prev_err;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("cmd_ready_vs_outstanding", 32'(cmd_ready), 32'(q.size() != 2));
      if (prev_stall) begin
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rdata", rsp_rdata, prev_rdata);
        chk("stall_err", 32'(rsp_err), 32'(prev_err));
      end
      if (rsp_valid) chk("rsp_has_pending_cmd", 32'(q.size() != 0), 32'd1);
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_err", 32'(rsp_err), 32'(e.err));
        if (e.known) chk("sb_rdata", rsp_rdata, e.rdata);
      end
      prev_stall = rsp_valid & ~rsp_ready;
      prev_rdata = rsp_rdata;
      prev_err   = rsp_err;
      if (cmd_valid && cmd_ready) q.push_back(model_cmd(cmd_read, cmd_addr, cmd_wdata, cmd_wmask));
    end
  end

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Single command with rsp_ready=1 on an idle slave: response must show up exactly one cycle later.
  task automatic xfer(input vec_t v, input string nm);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_read = v.rd; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wmask = v.wmask; rsp_ready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("%s_accept", nm), 32'(cmd_ready), 32'd1);
    chk($sformatf("%s_no_same_cycle_rsp", nm), 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_rsp_valid", nm), 32'(rsp_valid), 32'd1);
    chk($sformatf("%s_rdata", nm), rsp_rdata, v.exp_rdata);
    chk($sformatf("%s_err", nm), 32'(rsp_err), 32'(v.exp_err));
  endtask

  // Drive a command from the next cycle on and return in the cycle it is accepted.
  task automatic stream_cmd(input bit rd, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("stream_cmd_accept", 32'(cmd_ready), 32'd1);
  endtask

  vec_t tbl[16];

  initial begin
    int r;
    tbl[0]  = '{1'b0, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b1, 32'h1000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h1000_0010, 32'h0000_AA00, 4'h2, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h1000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
    tbl[4]  = '{1'b0, 32'h1000_0000, 32'h1111_1111, 4'hF, 32'h0, 1'b0};
    tbl[5]  = '{1'b0, 32'h1000_3FFC, 32'h2222_2222, 4'hF, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0FFF_FFFC, 32'h0,         4'h0, 32'h0, 1'b1};
    tbl[7]  = '{1'b1, 32'h1000_4000, 32'h0,         4'h0, 32'h0, 1'b1};
    tbl[8]  = '{1'b0, 32'h1000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 32'h0FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    tbl[10] = '{1'b1, 32'h1000_0000, 32'h0,         4'h0, 32'h1111_1111, 1'b0};
    tbl[11] = '{1'b1, 32'h1000_3FFC, 32'h0,         4'h0, 32'h2222_2222, 1'b0};
    tbl[12] = '{1'b0, 32'h1000_0010, 32'h0,         4'h0, 32'h0, 1'b0};
    tbl[13] = '{1'b1, 32'h1000_0013, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
    tbl[14] = '{1'b0, 32'h1000_0010, 32'h1234_5678, 4'h9, 32'h0, 1'b0};
    tbl[15] = '{1'b1, 32'h1000_0010, 32'h0,         4'h0, 32'h12AD_AA78, 1'b0};

    #2;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) xfer(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: three reads with rsp_ready low; the third waits for a slot.
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h1000_0010;
    @(negedge clk); chk("bp_ready_cnt0", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1 cmd_addr = 32'h1000_0000;
    @(negedge clk);
    chk("bp_ready_cnt1", 32'(cmd_ready), 32'd1);
    chk("bp_first_rsp_t1", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1 cmd_addr = 32'h1000_3FFC;
    @(negedge clk); chk("bp_ready_full", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_full_hold", 32'(cmd_ready), 32'd0);
    chk("bp_head_rdata", rsp_rdata, 32'h12AD_AA78);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_still_full", 32'(cmd_ready), 32'd0);
    chk("bp_rsp0_rdata", rsp_rdata, 32'h12AD_AA78);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_third_accept", 32'(cmd_ready), 32'd1);
    chk("bp_rsp1_rdata", rsp_rdata, 32'h1111_1111);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp2_rdata", rsp_rdata, 32'h2222_2222);
    @(posedge clk); #1;
    @(negedge clk); chk("bp_drained", 32'(rsp_valid), 32'd0);

    // Reset with two responses pending.
    @(posedge clk); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h1000_0000;
    @(posedge clk); #1 cmd_addr = 32'h1000_3FFC;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", 32'(rsp_valid), 32'd1);
    chk("rst_pre_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_rdata", rsp_rdata, 32'd0);
    chk("rst_mid_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    xfer('{1'b1, 32'h1000_3FFC, 32'h0, 4'h0, 32'h2222_2222, 1'b0}, "post_rst");

    // Randomized traffic against the scoreboard, after seeding a 16-word window.
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) stream_cmd(1'b0, BASE + 32'(4 * i), $urandom, 4'hF);
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      cmd_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cmd_read  = 1'($urandom_range(0, 1));
      cmd_wdata = $urandom;
      cmd_wmask = 4'($urandom_range(0, 15));
      r = int'($urandom_range(0, 9));
      if (r == 0)      cmd_addr = BASE - 32'(4 * $urandom_range(1, 4));
      else if (r == 1) cmd_addr = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 255));
      else             cmd_addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
    end
    @(posedge clk); #1 cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("rand_drained", 32'(rsp_valid), 32'd0);

    // Eight back-to-back reads: one accept per cycle, responses from T+1 onward.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = BASE + 32'(4 * i);
      @(negedge clk);
      chk("stream_ready", 32'(cmd_ready), 32'd1);
      chk("stream_rsp_valid", 32'(rsp_valid), 32'(i > 0));
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); chk("stream_last_rsp", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("stream_idle", 32'(rsp_valid), 32'd0);

    // Read immediately after write to the same word.
    stream_cmd(1'b0, BASE + 32'h20, 32'hCAFE_F00D, 4'hF);
    stream_cmd(1'b1, BASE + 32'h20, 32'h0, 4'h0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("raw_valid", 32'(rsp_valid), 32'd1);
    chk("raw_rdata", rsp_rdata, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
